// File: rtl/uart_pkt_framer_if.sv
// Byte-level start/done handshake between the packet framer and the UART
// byte transmitter. The framer drives the master side.
interface uart_pkt_framer_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output tx_start,
    output tx_data,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  tx_start,
    input  tx_data,
    output tx_busy,
    output tx_done
  );
endinterface

// File: rtl/uart_pkt_framer.sv
// UART packet framer: snapshots the registered coordinate, timer and status
// fields into a SYNC / payload / XOR-checksum packet. The packet is then
// handed to the byte transmitter one byte at a time.
// One request arriving mid-packet is queued. Further requests are counted
// in merge_cnt. A transmitter that never answers aborts the packet and
// raises the sticky tx_err.
// Optional macro UART_PKT_EOP_EN appends an EOP_BYTE trailer after the
// checksum.
module uart_pkt_framer #(
  parameter logic [7:0] SYNC_BYTE  = 8'hAA,
  parameter logic [7:0] EOP_BYTE   = 8'h55,
  parameter int         TX_TIMEOUT = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart_start,
  input  logic [9:0]        x_min,
  input  logic [9:0]        x_max,
  input  logic [9:0]        y_min,
  input  logic [9:0]        y_max,
  input  logic [4:0]        red_left_time,
  input  logic [4:0]        green_left_time,
  input  logic              traffic_light,
  input  logic              human_violation,
  input  logic              car_violation,
  input  logic              traffic_amount,
  uart_pkt_framer_if.master tx,
  output logic              pkt_busy,
  output logic              pkt_done,
  output logic [7:0]        merge_cnt,
  output logic              tx_err
);

  localparam int TW = $clog2(TX_TIMEOUT);

`ifdef UART_PKT_EOP_EN
  localparam logic [3:0] LAST_IDX = 4'd13;
`else
  localparam logic [3:0] LAST_IDX = 4'd12;
`endif

  typedef enum logic [2:0] {IDLE, SNAP, SEND, WAIT, NEXT, DONE} state_t;

  state_t         state;
  state_t         next_state;

  logic [9:0]     snap_x_min;
  logic [9:0]     snap_x_max;
  logic [9:0]     snap_y_min;
  logic [9:0]     snap_y_max;
  logic [4:0]     snap_red;
  logic [4:0]     snap_green;
  logic [3:0]     snap_flags;

  logic [3:0]     idx;
  logic [7:0]     csum;
  logic [TW-1:0]  to_cnt;
  logic           pending;
  logic           launch;
  logic           timeout_hit;
  logic [7:0]     cur_byte;

  assign timeout_hit = (to_cnt == TW'(TX_TIMEOUT - 1));

  // Select the byte at the current index from the snapshot; index 13 only exists with the trailer
  always_comb begin
    cur_byte = EOP_BYTE;
    case (idx)
      4'd0:    cur_byte = SYNC_BYTE;
      4'd1:    cur_byte = {6'b0, snap_x_min[9:8]};
      4'd2:    cur_byte = snap_x_min[7:0];
      4'd3:    cur_byte = {6'b0, snap_x_max[9:8]};
      4'd4:    cur_byte = snap_x_max[7:0];
      4'd5:    cur_byte = {6'b0, snap_y_min[9:8]};
      4'd6:    cur_byte = snap_y_min[7:0];
      4'd7:    cur_byte = {6'b0, snap_y_max[9:8]};
      4'd8:    cur_byte = snap_y_max[7:0];
      4'd9:    cur_byte = {3'b0, snap_red};
      4'd10:   cur_byte = {3'b0, snap_green};
      4'd11:   cur_byte = {4'b0, snap_flags};
      4'd12:   cur_byte = csum;
      default: cur_byte = EOP_BYTE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic for the packet sequencer
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (uart_start) next_state = SNAP;
      SNAP: next_state = SEND;
      SEND: if (!tx.tx_busy) next_state = WAIT;
      WAIT: begin
        if (tx.tx_done) begin
          next_state = NEXT;
        end else if (timeout_hit) begin
          next_state = IDLE;
        end
      end
      NEXT: next_state = (idx == LAST_IDX) ? DONE : SEND;
      DONE: next_state = pending ? SNAP : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the current state
  always_comb begin
    launch      = (state == SEND) && !tx.tx_busy;
    tx.tx_start = launch;
    tx.tx_data  = launch ? cur_byte : 8'h00;
    pkt_done    = (state == DONE);
    pkt_busy    = (state == SNAP) || (state == SEND) ||
                  (state == WAIT) || (state == NEXT);
  end

  // Snapshot, byte index, running checksum, timeout counter and sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_x_min <= '0;
      snap_x_max <= '0;
      snap_y_min <= '0;
      snap_y_max <= '0;
      snap_red   <= '0;
      snap_green <= '0;
      snap_flags <= '0;
      idx        <= '0;
      csum       <= '0;
      to_cnt     <= '0;
      tx_err     <= 1'b0;
    end else begin
      case (state)
        SNAP: begin
          snap_x_min <= x_min;
          snap_x_max <= x_max;
          snap_y_min <= y_min;
          snap_y_max <= y_max;
          snap_red   <= red_left_time;
          snap_green <= green_left_time;
          snap_flags <= {traffic_amount, car_violation, human_violation, traffic_light};
          idx        <= '0;
          csum       <= '0;
        end
        SEND: begin
          if (launch) begin
            to_cnt <= '0;
            if (idx >= 4'd1 && idx <= 4'd11) begin
              csum <= csum ^ cur_byte;
            end
          end
        end
        WAIT: begin
          if (!tx.tx_done) begin
            if (timeout_hit) begin
              tx_err <= 1'b1;
            end else begin
              to_cnt <= to_cnt + TW'(1);
            end
          end
        end
        NEXT: begin
          if (idx != LAST_IDX) begin
            idx <= idx + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Queue one request seen while busy and count the ones merged into it
  always_ff @(posedge clk) begin
    if (reset) begin
      pending   <= 1'b0;
      merge_cnt <= 8'h00;
    end else if (state == DONE && pending) begin
      pending <= 1'b0;
      if (uart_start && merge_cnt != 8'hFF) begin
        merge_cnt <= merge_cnt + 8'd1;
      end
    end else if (state != IDLE && uart_start) begin
      if (!pending) begin
        pending <= 1'b1;
      end else if (merge_cnt != 8'hFF) begin
        merge_cnt <= merge_cnt + 8'd1;
      end
    end
  end

endmodule
